trigger_conditioner: RTL
========================

# trigger_conditioner

Conditions the buffered external trigger (single-ended output of the TRIG1 differential input buffer) before it reaches the `Trigger` input of the sequencer in the PL system. The block:
- synchronizes the asynchronous level into `aclk`;
- rejects glitches shorter than a programmable number of cycles;
- selects rising or falling edge;
- emits one single-cycle trigger pulse per qualifying edge while armed, with a programmable holdoff window.

## Interface

Parameters:
- `FILTER_LEN`, 4: consecutive `aclk` cycles a new level must persist to be accepted (≥1).
- `HOLDOFF_W`, 32: width of the holdoff count.
- `COUNT_W`, 32: width of the event counters.

Ports:
- `aclk` input, 1: sole clock. One clock; all logic is in this domain.
- `aresetn` input, 1: reset, asynchronous assert, active-low.
- `trig_in` input, 1: raw trigger level, asynchronous to `aclk`.
- `arm` input, 1: single-cycle request to arm.
- `disarm` input, 1: single-cycle request to disarm.
- `edge_sel` input, 1: 0 = rising, 1 = falling.
- `auto_rearm` input, 1: 1 = return to ARMED after holdoff; 0 = return to IDLE.
- `holdoff` input, HOLDOFF_W: holdoff length, sampled at fire.
- `count_clr` input, 1: clears both counters.
- `trig_pulse` output, 1: one-cycle trigger to the sequencer.
- `trig_level` output, 1: filtered, synchronized level.
- `armed` output, 1: high in ARMED and HOLDOFF.
- `trig_count` output, COUNT_W: pulses issued; wraps.
- `missed_count` output, COUNT_W: qualifying edges seen during HOLDOFF; saturates at all-ones.

## Operation

- **Sync and filter.**
  - Two-flop synchronizer `s1` → `s2`.
  - Filter counter resets whenever `s2 == trig_level`.
  - While `s2 != trig_level`, the counter increments each cycle. When `s2` has differed for FILTER_LEN consecutive sampling edges, `trig_level <= s2`.
  - `lvl_d` holds the previous `trig_level`.
  - Qualifying edge (combinational) is:
    - rising: `trig_level & ~lvl_d`
    - falling: `~trig_level & lvl_d`
- **States (shared enum): IDLE, ARMED, HOLDOFF.**
  - IDLE: `arm & ~disarm` → ARMED.
  - ARMED:
    - `disarm` → IDLE; this wins over a simultaneous edge, and no pulse is issued.
    - Otherwise, a qualifying edge → HOLDOFF, `trig_pulse <= 1`, `hcnt <= holdoff`.
    - `arm` is ignored.
  - HOLDOFF:
    - `disarm` → IDLE and clears `hcnt`.
    - Else if `hcnt == 0` → ARMED if `auto_rearm`, else IDLE.
    - Else `hcnt` decrements.
    - A qualifying edge in HOLDOFF increments `missed_count` and does not fire.
- **Counters.**
  - `trig_count` increments on each pulse, modulo 2^COUNT_W.
  - `missed_count` saturates.
  - `count_clr` zeroes both; if a clear coincides with an increment, the clear wins and the result is 0.
- `holdoff` changes during HOLDOFF have no effect until the next fire.

## Timing

- **Reset values:** all outputs 0; `s1`, `s2`, `trig_level`, `lvl_d`, filter counter and `hcnt` are 0; state is IDLE.
- **`trig_level` at reset release:** if `trig_in` is already 1, `trig_level` rises after FILTER_LEN+2 edges. This is not a pulse unless the block was armed before that point.
- **Latency:**
  - `trig_in` stable before edge 0 → `s2` valid after edge 2.
  - `trig_level` updates at edge 2+FILTER_LEN.
  - `trig_pulse` is high for exactly the one cycle after edge FILTER_LEN+3 (7 cycles at default).
- **Glitch rejection:** a pulse held for fewer than FILTER_LEN `s2` samples never changes `trig_level`.
- **Arming:** `arm` at edge n gives `armed = 1` after edge n; an edge is qualified from cycle n+1.
- **Holdoff length:** HOLDOFF lasts `holdoff`+1 cycles. The earliest next pulse is `holdoff`+2 cycles after the previous one, provided a new edge has been filtered by then.
- **Reset mid-operation:** asynchronous; `trig_pulse` drops immediately and the state returns to IDLE.

## Structure

- **Package `trig_pkg`:** state enum, `EDGE_RISE = 1'b0`, `EDGE_FALL = 1'b1`.
- **Sub-module `trig_input_filter`:** synchronizer, glitch filter, `lvl_d`, and edge outputs (`rise`, `fall`).
- **Top level:** state machine, holdoff counter and event counters.

## Test plan

- **Basic rising edge.** FILTER_LEN=4, armed, `edge_sel`=0, `trig_in` 0→1 → `trig_pulse` high exactly 1 cycle, 7 cycles after the edge; `trig_count` = 1.
- **Glitch rejection.** `trig_in` high for 3 cycles, then low → `trig_level` stays 0, no pulse, counts unchanged.
- **Holdoff.** `holdoff`=10, `auto_rearm`=1, second edge 5 cycles after the first pulse → no second pulse, `missed_count` = 1. A third edge after holdoff → pulse, `trig_count` = 2.
- **Single-shot.** `auto_rearm`=0 → after holdoff `armed` = 0; a later edge gives no pulse until `arm`.
- **Priority.** `disarm` coincident with a qualifying edge → no pulse, IDLE. `count_clr` coincident with a pulse → `trig_count` = 0.
- **Reset and counter limits.**
  - `aresetn` low during HOLDOFF → all outputs 0 immediately.
  - COUNT_W=4: 16 pulses → `trig_count` wraps to 0.
  - COUNT_W=4: 20 missed edges → `missed_count` holds 15.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared types and constants for the external trigger conditioner.
package trig_pkg;

  // Sequencer-facing trigger state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_e;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Pick the edge flavour the sequencer cares about
  function automatic logic qualify_edge(input logic sel, input logic rise, input logic fall);
    logic q;
    if (sel == EDGE_FALL) begin
      q = fall;
    end else begin
      q = rise;
    end
    return q;
  endfunction

endpackage

// File: rtl/trig_input_filter.sv
// Synchronizes the raw trigger level, rejects short glitches and
// produces single-cycle rise/fall strobes of the filtered level.
module trig_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic trig_in,
  output logic trig_level,
  output logic rise,
  output logic fall
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              level_q, level_d;
  logic              prev_level_q, prev_level_d;  // previous filtered level
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Next-state for synchronizer, persistence counter and level history
  always_comb begin
    s1_d         = trig_in;
    s2_d         = s1_q;
    prev_level_d = level_q;
    level_d      = level_q;
    fcnt_d       = fcnt_q;
    if (s2_q == level_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_LAST) begin
      // New level has persisted for FILTER_LEN consecutive samples
      level_d = s2_q;
      fcnt_d  = '0;
    end else begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  // State registers of the input path
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      level_q      <= 1'b0;
      prev_level_q <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      level_q      <= level_d;
      prev_level_q <= prev_level_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign trig_level = level_q;
  assign rise       = level_q & ~prev_level_q;
  assign fall       = ~level_q & prev_level_q;

endmodule

// File: rtl/trigger_conditioner.sv
// Trigger conditioner: filtered edge detection, arm/holdoff state machine
// and pulse/missed-edge event counters feeding the sequencer Trigger input.
module trigger_conditioner
  import trig_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int HOLDOFF_W  = 32,
  parameter int COUNT_W    = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 trig_in,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic                 edge_sel,
  input  logic                 auto_rearm,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 count_clr,
  output logic                 trig_pulse,
  output logic                 trig_level,
  output logic                 armed,
  output logic [COUNT_W-1:0]   trig_count,
  output logic [COUNT_W-1:0]   missed_count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic rise_s, fall_s, qual_s;
  logic fire_s, miss_s;

  trig_state_e          state_q, state_d;
  logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
  logic                 pulse_q, pulse_d;
  logic                 armed_q, armed_d;
  logic [COUNT_W-1:0]   tcount_q, tcount_d;
  logic [COUNT_W-1:0]   mcount_q, mcount_d;

  trig_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .trig_in    (trig_in),
    .trig_level (trig_level),
    .rise       (rise_s),
    .fall       (fall_s)
  );

  assign qual_s = qualify_edge(edge_sel, rise_s, fall_s);

  // Arm/holdoff state machine and event counter next-state
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    fire_s  = 1'b0;
    miss_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm && !disarm) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // Disarm beats a coincident edge; arm is a no-op here
        if (disarm) begin
          state_d = ST_IDLE;
        end else if (qual_s) begin
          state_d = ST_HOLDOFF;
          fire_s  = 1'b1;
          hcnt_d  = holdoff;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_HOLDOFF: begin
        miss_s = qual_s;
        if (disarm) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end else if (hcnt_q == '0) begin
          if (auto_rearm) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q - HOLDOFF_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
      end
    endcase

    pulse_d = fire_s;
    armed_d = (state_d != ST_IDLE);

    // Clear wins over a simultaneous increment on both counters
    if (count_clr) begin
      tcount_d = '0;
    end else if (fire_s) begin
      tcount_d = tcount_q + COUNT_W'(1);
    end else begin
      tcount_d = tcount_q;
    end

    if (count_clr) begin
      mcount_d = '0;
    end else if (miss_s && (mcount_q != COUNT_MAX)) begin
      mcount_d = mcount_q + COUNT_W'(1);
    end else begin
      mcount_d = mcount_q;
    end
  end

  // Control state, holdoff count, counters and registered outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      pulse_q  <= 1'b0;
      armed_q  <= 1'b0;
      tcount_q <= '0;
      mcount_q <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pulse_q  <= pulse_d;
      armed_q  <= armed_d;
      tcount_q <= tcount_d;
      mcount_q <= mcount_d;
    end
  end

  assign trig_pulse   = pulse_q;
  assign armed        = armed_q;
  assign trig_count   = tcount_q;
  assign missed_count = mcount_q;

endmodule
